// File: rtl/ccc_reconfig_pkg.sv
// Shared types and widths for the CCC dynamic-configuration APB initiator.
package ccc_reconfig_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_WRITE  = 2'b01,
        OP_RELOCK = 2'b10,
        OP_RSVD   = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUSY,
        SETUP,
        ACCESS,
        RESP,
        ARST,
        WAIT_LOCK
    } state_e;

    // Larger of two unsigned values, used to size the shared counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ccc_lock_filter.sv
// LOCK synchronizer plus consecutive-high filter producing a qualified lock_ok.
// hit_c is high on the cycle whose edge will raise (or keep) lock_ok.
module ccc_lock_filter #(
    parameter int unsigned LOCK_FILTER = 64
) (
    input  logic PCLK,
    input  logic PRESET_N,
    input  logic LOCK,
    input  logic clr,
    output logic lock_ok,
    output logic hit_c
);

    localparam int unsigned FW = $clog2(LOCK_FILTER + 1);

    logic          lock_meta;
    logic          lock_s;
    logic [FW-1:0] cnt;
    logic [FW-1:0] cnt_next;

    // Saturating run length of synchronized LOCK; any low cycle or a clear restarts it.
    always_comb begin
        cnt_next = cnt;
        if (clr || !lock_s) begin
            cnt_next = '0;
        end else if (cnt < FW'(LOCK_FILTER)) begin
            cnt_next = cnt + FW'(1);
        end
    end

    assign hit_c = (cnt_next == FW'(LOCK_FILTER));

    // Two-flop synchronizer, run counter and registered lock status.
    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            cnt       <= '0;
            lock_ok   <= 1'b0;
        end else begin
            lock_meta <= LOCK;
            lock_s    <= lock_meta;
            cnt       <= cnt_next;
            lock_ok   <= hit_c;
        end
    end

endmodule

// File: rtl/ccc_apb_reconfig.sv
// APB initiator for the SF2 CCC dynamic-configuration port with PLL relock
// sequencing and lock supervision.
// Optional: define CCC_LOCK_LOSS_IRQ_EN to add a sticky lock-loss interrupt.
module ccc_apb_reconfig
    import ccc_reconfig_pkg::*;
#(
    parameter int unsigned ARST_CYCLES  = 16,
    parameter int unsigned LOCK_FILTER  = 64,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned BUSY_TIMEOUT = 255
) (
    input  logic              PCLK,
    input  logic              PRESET_N,
`ifdef CCC_LOCK_LOSS_IRQ_EN
    output logic              lock_lost_irq,
    input  logic              lock_lost_clr,
`endif
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              BUSY,
    input  logic              LOCK,
    output logic              PLL_ARST_N,
    output logic              lock_ok
);

    localparam int unsigned MAXP = max_u(max_u(ARST_CYCLES, LOCK_FILTER),
                                         max_u(LOCK_TIMEOUT, BUSY_TIMEOUT));
    localparam int unsigned CW   = $clog2(MAXP) + 1;

    state_e            state;
    cmd_op_e           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_inc;
    logic              filt_clr_c;
    logic              lock_hit_c;

    assign cnt_inc = cnt + CW'(1);

    // Hold the filter clear from the relock accept edge through the whole reset phase.
    assign filt_clr_c = (state == ARST) ||
                        ((state == IDLE) && cmd_valid && (cmd_op == OP_RELOCK));

    ccc_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .PCLK     (PCLK),
        .PRESET_N (PRESET_N),
        .LOCK     (LOCK),
        .clr      (filt_clr_c),
        .lock_ok  (lock_ok),
        .hit_c    (lock_hit_c)
    );

    // Command FSM; every output is registered and set on the edge entering the state that owns it.
    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            state      <= IDLE;
            op_q       <= OP_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            PLL_ARST_N <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op_e'(cmd_op);
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        cnt       <= '0;
                        cmd_ready <= 1'b0;
                        rsp_rdata <= '0;
                        case (cmd_op_e'(cmd_op))
                            OP_READ, OP_WRITE: state <= WAIT_BUSY;
                            OP_RELOCK: begin
                                state      <= ARST;
                                PLL_ARST_N <= 1'b0;
                            end
                            default: begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                WAIT_BUSY: begin
                    if (!BUSY) begin
                        state   <= SETUP;
                        cnt     <= '0;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PWRITE  <= (op_q == OP_WRITE);
                        PADDR   <= addr_q;
                        PWDATA  <= wdata_q;
                    end else if (cnt_inc >= CW'(BUSY_TIMEOUT)) begin
                        state     <= RESP;
                        cnt       <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    cnt     <= '0;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    // No PREADY on the CCC: the access phase is always a single cycle.
                    state     <= RESP;
                    cnt       <= '0;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    rsp_valid <= 1'b1;
                    if (op_q == OP_READ) begin
                        rsp_rdata <= PRDATA;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    cmd_ready <= 1'b1;
                end
                ARST: begin
                    if (cnt_inc >= CW'(ARST_CYCLES)) begin
                        state      <= WAIT_LOCK;
                        cnt        <= '0;
                        PLL_ARST_N <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_LOCK: begin
                    // A filtered lock on the timeout cycle still counts as success.
                    if (lock_hit_c) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                    end else if (cnt_inc >= CW'(LOCK_TIMEOUT)) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef CCC_LOCK_LOSS_IRQ_EN
    logic lock_ok_d;
    logic lock_fall_c;

    // Only unexpected losses count; the relock sequence drops lock_ok on purpose.
    assign lock_fall_c = lock_ok_d && !lock_ok && (state != ARST) && (state != WAIT_LOCK);

    // Sticky lock-loss flag; a new loss beats a simultaneous clear.
    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            lock_ok_d     <= 1'b0;
            lock_lost_irq <= 1'b0;
        end else begin
            lock_ok_d <= lock_ok;
            if (lock_fall_c) begin
                lock_lost_irq <= 1'b1;
            end else if (lock_lost_clr) begin
                lock_lost_irq <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ccc_apb_reconfig.sv
// Directed self-checking bench for ccc_apb_reconfig (LOCK_TIMEOUT shortened to 1000).
module tb_ccc_apb_reconfig;

    logic       PCLK = 1'b0;
    logic       PRESET_N = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [5:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [5:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA = '0;
    logic       BUSY = 1'b0;
    logic       LOCK = 1'b0;
    logic       PLL_ARST_N;
    logic       lock_ok;
`ifdef CCC_LOCK_LOSS_IRQ_EN
    logic       lock_lost_irq;
    logic       lock_lost_clr = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 PCLK = ~PCLK;

    ccc_apb_reconfig #(
        .ARST_CYCLES  (16),
        .LOCK_FILTER  (64),
        .LOCK_TIMEOUT (1000),
        .BUSY_TIMEOUT (255)
    ) dut (
        .PCLK          (PCLK),
        .PRESET_N      (PRESET_N),
`ifdef CCC_LOCK_LOSS_IRQ_EN
        .lock_lost_irq (lock_lost_irq),
        .lock_lost_clr (lock_lost_clr),
`endif
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PWRITE        (PWRITE),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PRDATA        (PRDATA),
        .BUSY          (BUSY),
        .LOCK          (LOCK),
        .PLL_ARST_N    (PLL_ARST_N),
        .lock_ok       (lock_ok)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Present a command for one cycle; returns just after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [5:0] addr, input logic [7:0] data);
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int   n;
        int   low_cnt;
        logic bad;

        // Reset state
        tick(); tick(); tick();
        check_eq("rst_psel", 32'(PSEL), 0);
        check_eq("rst_penable", 32'(PENABLE), 0);
        check_eq("rst_arst_n", 32'(PLL_ARST_N), 1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        check_eq("rst_lock_ok", 32'(lock_ok), 0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 1);
        PRESET_N = 1'b1;
        tick();

        // Write 0x05 <= 0xA3
        issue(2'b01, 6'h05, 8'hA3);
        check_eq("wr_ready_low", 32'(cmd_ready), 0);
        check_eq("wr_wb_psel", 32'(PSEL), 0);
        tick();
        check_eq("wr_setup_psel", 32'(PSEL), 1);
        check_eq("wr_setup_pen", 32'(PENABLE), 0);
        check_eq("wr_paddr", 32'(PADDR), 32'h05);
        check_eq("wr_pwdata", 32'(PWDATA), 32'hA3);
        check_eq("wr_pwrite", 32'(PWRITE), 1);
        tick();
        check_eq("wr_access_pen", 32'(PENABLE), 1);
        check_eq("wr_access_psel", 32'(PSEL), 1);
        check_eq("wr_early_rsp", 32'(rsp_valid), 0);
        tick();
        check_eq("wr_rsp_valid", 32'(rsp_valid), 1);
        check_eq("wr_rsp_err", 32'(rsp_err), 0);
        check_eq("wr_rsp_rdata", 32'(rsp_rdata), 0);
        check_eq("wr_resp_psel", 32'(PSEL), 0);
        tick();
        check_eq("wr_rsp_pulse", 32'(rsp_valid), 0);
        check_eq("wr_ready_back", 32'(cmd_ready), 1);
        check_eq("wr_paddr_hold", 32'(PADDR), 32'h05);

        // Read 0x12, CCC returns 0x5C
        PRDATA = 8'h5C;
        issue(2'b00, 6'h12, 8'h00);
        tick();
        check_eq("rd_pwrite", 32'(PWRITE), 0);
        check_eq("rd_paddr", 32'(PADDR), 32'h12);
        tick();
        tick();
        PRDATA = 8'h00;
        check_eq("rd_rsp_valid", 32'(rsp_valid), 1);
        check_eq("rd_rsp_rdata", 32'(rsp_rdata), 32'h5C);
        check_eq("rd_rsp_err", 32'(rsp_err), 0);
        tick();

        // BUSY high for two WAIT_BUSY cycles delays the transfer by two
        BUSY = 1'b1;
        issue(2'b01, 6'h20, 8'h11);
        tick();
        tick();
        check_eq("bd_no_psel", 32'(PSEL), 0);
        BUSY = 1'b0;
        tick();
        check_eq("bd_psel", 32'(PSEL), 1);
        check_eq("bd_paddr", 32'(PADDR), 32'h20);
        tick();
        tick();
        check_eq("bd_rsp_valid", 32'(rsp_valid), 1);
        check_eq("bd_rsp_err", 32'(rsp_err), 0);
        tick();

        // BUSY stuck high: timeout response on cycle 256 after accept, never any PSEL
        BUSY = 1'b1;
        issue(2'b00, 6'h01, 8'h00);
        bad = 1'b0;
        for (int i = 1; i <= 254; i++) begin
            tick();
            bad = bad | PSEL | rsp_valid;
        end
        check_eq("bt_quiet", 32'(bad), 0);
        tick();
        check_eq("bt_rsp_valid", 32'(rsp_valid), 1);
        check_eq("bt_rsp_err", 32'(rsp_err), 1);
        check_eq("bt_rsp_rdata", 32'(rsp_rdata), 0);
        bad = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick();
            bad = bad | PSEL | PENABLE;
        end
        check_eq("bt_no_psel", 32'(bad), 0);
        BUSY = 1'b0;
        tick();
        check_eq("bt_ready", 32'(cmd_ready), 1);

        // Reserved op errors on the next cycle
        issue(2'b11, 6'h00, 8'h00);
        check_eq("rsv_rsp_valid", 32'(rsp_valid), 1);
        check_eq("rsv_rsp_err", 32'(rsp_err), 1);
        check_eq("rsv_psel", 32'(PSEL), 0);
        tick();
        check_eq("rsv_pulse", 32'(rsp_valid), 0);
        check_eq("rsv_ready", 32'(cmd_ready), 1);

        // Relock: 16-cycle PLL reset, LOCK at +100 with a one-cycle glitch at +30
        issue(2'b10, 6'h00, 8'h00);
        check_eq("rl_lock_ok_low", 32'(lock_ok), 0);
        low_cnt = 0;
        n = 0;
        while (PLL_ARST_N == 1'b0 && n < 100) begin
            low_cnt++;
            tick();
            n++;
        end
        check_eq("rl_arst_cycles", 32'(low_cnt), 16);
        bad = 1'b0;
        for (int i = 1; i <= 99; i++) begin
            tick();
            bad = bad | lock_ok | rsp_valid;
        end
        LOCK = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            bad = bad | lock_ok | rsp_valid;
        end
        LOCK = 1'b0;
        tick();
        bad = bad | lock_ok | rsp_valid;
        LOCK = 1'b1;
        for (int i = 0; i < 65; i++) begin
            tick();
            bad = bad | lock_ok | rsp_valid;
        end
        check_eq("rl_no_early_lock", 32'(bad), 0);
        tick();
        check_eq("rl_lock_ok", 32'(lock_ok), 1);
        check_eq("rl_rsp_valid", 32'(rsp_valid), 1);
        check_eq("rl_rsp_err", 32'(rsp_err), 0);
        check_eq("rl_ready", 32'(cmd_ready), 1);
        tick();
        check_eq("rl_pulse", 32'(rsp_valid), 0);
        check_eq("rl_lock_hold", 32'(lock_ok), 1);

        // Lock loss in IDLE: lock_ok drops three edges after LOCK falls
`ifdef CCC_LOCK_LOSS_IRQ_EN
        check_eq("irq_idle_low", 32'(lock_lost_irq), 0);
`endif
        LOCK = 1'b0;
        tick();
        tick();
        check_eq("ll_lock_ok_still", 32'(lock_ok), 1);
        tick();
        check_eq("ll_lock_ok_drop", 32'(lock_ok), 0);
`ifdef CCC_LOCK_LOSS_IRQ_EN
        tick();
        check_eq("irq_set", 32'(lock_lost_irq), 1);
        tick(); tick(); tick();
        check_eq("irq_sticky", 32'(lock_lost_irq), 1);
        lock_lost_clr = 1'b1;
        tick();
        lock_lost_clr = 1'b0;
        check_eq("irq_cleared", 32'(lock_lost_irq), 0);
`endif
        tick();

        // Relock with LOCK stuck low: timeout after 1000 WAIT_LOCK cycles
        issue(2'b10, 6'h00, 8'h00);
        n = 0;
        while (PLL_ARST_N == 1'b0 && n < 100) begin
            tick();
            n++;
        end
        n = 0;
        while (rsp_valid == 1'b0 && n < 1100) begin
            tick();
            n++;
        end
        check_eq("to_wait_cycles", 32'(n), 1000);
        check_eq("to_rsp_err", 32'(rsp_err), 1);
        check_eq("to_lock_ok", 32'(lock_ok), 0);
        tick();
        check_eq("to_ready", 32'(cmd_ready), 1);

        // Reset during ACCESS aborts with no response
        issue(2'b01, 6'h07, 8'h55);
        tick();
        tick();
        check_eq("ra_in_access", 32'(PENABLE), 1);
        PRESET_N = 1'b0;
        tick();
        check_eq("ra_psel", 32'(PSEL), 0);
        check_eq("ra_penable", 32'(PENABLE), 0);
        check_eq("ra_arst_n", 32'(PLL_ARST_N), 1);
        check_eq("ra_rsp_valid", 32'(rsp_valid), 0);
        check_eq("ra_paddr", 32'(PADDR), 0);
        PRESET_N = 1'b1;
        tick();
        check_eq("ra_ready", 32'(cmd_ready), 1);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            bad = bad | rsp_valid | PSEL;
        end
        check_eq("ra_no_rsp", 32'(bad), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ccc_apb_reconfig.md
Name: ccc_apb_reconfig

Overview:
- APB initiator for the SF2 fabric CCC's dynamic-configuration port. Drives PSEL/PENABLE/PWRITE/PADDR/PWDATA and samples PRDATA/BUSY; the CCC is the APB responder.
- Accepts single read, write and relock commands from fabric control logic.
- Sequences the PLL async reset and supervises the CCC LOCK output with a filter and a timeout, so GL0 consumers get a qualified lock_ok.

Parameters:
ARST_CYCLES, 16, PCLK cycles PLL_ARST_N is held low during a relock (>=1)
LOCK_FILTER, 64, consecutive PCLK cycles synchronized LOCK must stay high before lock_ok asserts (>=1)
LOCK_TIMEOUT, 65535, max PCLK cycles to wait for a filtered lock after the reset phase
BUSY_TIMEOUT, 255, max PCLK cycles to wait for BUSY low before an APB transfer

Ports:
PCLK  in  1  sole clock
PRESET_N  in  1  reset, synchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
cmd_op  in  2  00 read, 01 write, 10 relock, 11 reserved
cmd_addr  in  6  CCC register address
cmd_wdata  in  8  write data
rsp_valid  out  1  one-cycle completion pulse; no backpressure
rsp_rdata  out  8  read data; 0 for non-read commands
rsp_err  out  1  qualifies rsp_valid: timeout or reserved op
PSEL, PENABLE, PWRITE  out  1 each  APB control
PADDR  out  6  APB address
PWDATA  out  8  APB write data
PRDATA  in  8  APB read data
BUSY  in  1  CCC busy; no APB transfer may start while high
LOCK  in  1  CCC PLL lock, asynchronous to PCLK
PLL_ARST_N  out  1  PLL async reset, active-low
lock_ok  out  1  filtered lock status

Behaviour:
- Reset (PRESET_N low at a PCLK edge). All APB outputs go to 0, PLL_ARST_N=1, rsp_*=0 and lock_ok=0. State goes to IDLE, and the counter, filter and synchronizer clear.
- Reset mid-transfer aborts the transfer with no response.
- LOCK passes through a 2-flop synchronizer (lock_s) before any use.
- Counter: a single shared counter, width $clog2(max parameter)+1, reloaded on every state entry.
- IDLE. cmd_ready=1. On accept, command fields are registered.
  - op 11: rsp_valid=1 with rsp_err=1 on the next cycle, then back to IDLE.
  - op 10: go to ARST.
  - op 00 or 01: go to WAIT_BUSY.
- WAIT_BUSY. Go to SETUP on the first cycle BUSY=0.
  - After BUSY_TIMEOUT cycles with BUSY still high: rsp_err=1, go to RESP.
- SETUP. PSEL=1, PENABLE=0, with PADDR/PWRITE/PWDATA driven. Next state is ACCESS.
- ACCESS. PSEL=1, PENABLE=1. The CCC has no PREADY, so ACCESS is exactly one cycle.
  - A read captures PRDATA on this edge.
  - Next state is RESP.
- RESP. Drops PSEL/PENABLE, pulses rsp_valid, returns to IDLE.
- Command latency: accept to rsp_valid = 4 cycles when BUSY=0 (WAIT_BUSY, SETUP, ACCESS, RESP).
- ARST. PLL_ARST_N=0 and lock_ok=0 for ARST_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK. PLL_ARST_N=1.
  - The filter counts consecutive lock_s=1 cycles; any lock_s=0 resets it to 0.
  - Filter reaches LOCK_FILTER: lock_ok=1, rsp_valid (rsp_err=0), go to IDLE.
  - Timeout counter reaches LOCK_TIMEOUT first: rsp_err=1, lock_ok=0, go to IDLE.
  - If both events fall on the same cycle, success wins.
- Lock filter outside WAIT_LOCK:
  - it runs continuously, and lock_ok follows it;
  - any lock_s=0 cycle clears lock_ok next cycle;
  - lock_ok reasserts after LOCK_FILTER consecutive high cycles.
- cmd_valid outside IDLE is ignored (cmd_ready=0); there is no queueing.
- APB outputs are registered. PADDR/PWDATA hold their value after a transfer, but PSEL=0.

Optional Feature:
- Macro: CCC_LOCK_LOSS_IRQ_EN.
- When defined:
  - adds ports lock_lost_irq (out, 1) and lock_lost_clr (in, 1);
  - the sticky flag sets when lock_ok falls outside ARST/WAIT_LOCK;
  - the flag clears on lock_lost_clr; if set and clear fall on the same cycle, set wins;
  - the flag resets to 0.
- When undefined: those ports and all related logic are absent; behaviour is otherwise identical.

Decomposition:
- Package ccc_reconfig_pkg holds:
  - enum cmd_op_e (OP_READ, OP_WRITE, OP_RELOCK, OP_RSVD);
  - state enum (IDLE, WAIT_BUSY, SETUP, ACCESS, RESP, ARST, WAIT_LOCK);
  - APB widths: ADDR_W=6, DATA_W=8.
- One natural sub-module: ccc_lock_filter (synchronizer, consecutive-high counter, lock_ok), clocked by PCLK with the same reset.

Test Plan:
- Write addr 0x05 data 0xA3, BUSY=0 -> one SETUP+ACCESS with PADDR=0x05, PWDATA=0xA3, PWRITE=1; rsp_valid 4 cycles after accept, rsp_err=0.
- Read addr 0x12, model PRDATA=0x5C -> PWRITE=0, rsp_rdata=0x5C.
- BUSY held high 300 cycles, BUSY_TIMEOUT=255 -> no PSEL ever; rsp_err=1 at cycle 256 after accept.
- Relock, LOCK rises 100 cycles after PLL_ARST_N releases and glitches low once at +30 -> PLL_ARST_N low exactly 16 cycles; lock_ok and success rsp only after 64 consecutive high synchronized cycles.
- Relock with LOCK stuck at 0, LOCK_TIMEOUT=1000 -> rsp_err=1 after 1000 WAIT_LOCK cycles, lock_ok=0; op 11 -> rsp_err next cycle.
- PRESET_N low during ACCESS -> next cycle PSEL=PENABLE=0, PLL_ARST_N=1, no rsp_valid, cmd_ready=1 after release. With CCC_LOCK_LOSS_IRQ_EN, drop LOCK in IDLE -> lock_lost_irq=1 until lock_lost_clr.
